r200_ex_ctrl: RTL and testbench
===============================

# r200_ex_ctrl

Sequencing controller for the r200 execute stage. Accepts decoded instructions from ID over a valid/ready handshake and presents operands to the combinational EX datapath (ALU, comparator, jump-target generator). It launches and waits on the external iterative divider for divide ops and registers results into the EX/MEM handoff. It also turns taken branches and jumps into a one-cycle redirect and a flush of the younger stage.

## Interface
Parameters:
- DIV_MAX_CYCLES, 40, divider watchdog limit in cycles after div_start
- XLEN, 32, datapath width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  ID holds an instruction
- id_ready  out  1  controller accepts this cycle
- id_is_branch  in  1  conditional branch; taken when ex_willbr=1
- id_is_jump  in  1  unconditional jump
- id_is_div  in  1  divide/remainder op; overrides branch/jump flags
- id_rd  in  5  destination register
- ex_alu_res  in  XLEN  EX datapath result, same cycle as accept
- ex_willbr  in  1  EX branch condition, same cycle as accept
- ex_jumptarg  in  XLEN  EX jump target, same cycle as accept
- div_start  out  1  one-cycle divider launch
- div_done  in  1  divider result valid; ignored outside DIV state
- div_res  in  XLEN  divider result
- mem_valid  out  1  EX/MEM register holds a result
- mem_ready  in  1  MEM consumes this cycle
- mem_res  out  XLEN  registered result
- mem_rd  out  5  registered destination
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  XLEN  redirect target
- flush  out  1  squash younger stage; equals redirect_valid
- div_err  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, DIV.
- Accept: id_valid & id_ready.
- id_ready = (state==IDLE) & ~flush & (~mem_valid | mem_ready).
- Non-div accept:
  - load mem_res <= ex_alu_res and mem_rd <= id_rd, and set mem_valid.
  - If id_is_jump, or id_is_branch & ex_willbr: next cycle redirect_valid=flush=1 and redirect_pc=ex_jumptarg.
- Div accept:
  - latch id_rd; next cycle div_start=1 and state goes to DIV; clear the watchdog counter.
- DIV:
  - id_ready=0.
  - On div_done: load mem_res <= div_res, mem_rd <= latched rd, set mem_valid, and return to IDLE.
  - The output register is guaranteed empty here, because a div is accepted only when it is empty or draining.
- Watchdog: counts cycles in DIV. On reaching DIV_MAX_CYCLES without div_done: set div_err (sticky until reset) and return to IDLE with no result written.
- mem_valid clears on mem_ready unless a new result is loaded in the same cycle. mem_res and mem_rd are stable while mem_valid & ~mem_ready.
- Flush cycle: id_ready=0, so the instruction ID presents in that cycle is never accepted.

## Timing
- Reset values: every output is 0, and state is IDLE.
- ALU/branch latency: accept in cycle N gives mem_valid and redirect in N+1.
- Throughput is 1/cycle with mem_ready=1 and no redirects. A taken branch costs one bubble (the flush cycle).
- Div: accept in N gives div_start in N+1. div_done is sampled from N+2 onward; div_done in cycle M gives mem_valid in M+1.
- div_done in the same cycle as mem_ready: legal, no conflict.
- Reset mid-DIV: return to IDLE and clear everything. A later div_done is ignored.
- mem_ready=0 held indefinitely: id_ready stays 0 and no state is lost.

## Structure
- Shared package r200_pkg: ex_state_t enum {IDLE, DIV}, XLEN, and the REG_ADDR_W=5 constant.
- One sub-module, r200_pipereg: the valid/ready EX/MEM output register (data, rd, valid, hold logic).
- The watchdog counter and the FSM live in r200_ex_ctrl.

## Test plan
- Back-to-back ALU ops with ex_alu_res=0x11,0x22,0x33 and mem_ready=1 -> mem_res 0x11,0x22,0x33 in consecutive cycles, id_ready held 1.
- Branch with ex_willbr=1, ex_jumptarg=0x100 -> next cycle redirect_valid=flush=1 and redirect_pc=0x100, id_ready=0 that cycle. Repeat with ex_willbr=0 -> no redirect.
- Div op, div_done 10 cycles after div_start with div_res=0xDEAD -> div_start for exactly one cycle, id_ready=0 throughout, mem_res=0xDEAD the cycle after div_done.
- mem_ready=0 for 5 cycles with mem_valid=1 -> mem_res stable, id_ready=0; on mem_ready=1 a new instruction is accepted in the same cycle.
- Div with no div_done -> div_err=1 after DIV_MAX_CYCLES=40, state IDLE, mem_valid=0, id_ready=1.
- rst_n=0 during DIV, then div_done pulsed after release -> all outputs 0, no mem_valid produced.

Source files
------------

// File: rtl/r200_pkg.sv
// Shared types and constants for the r200 execute stage.
package r200_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } ex_state_t;

endpackage

// File: rtl/r200_pipereg.sv
// EX/MEM output register with valid/ready hold: a held result stays put until MEM takes it.
module r200_pipereg #(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  load_res,
    input  logic [RW-1:0] load_rd,
    input  logic          ready,
    output logic          valid,
    output logic [W-1:0]  res,
    output logic [RW-1:0] rd
);

    logic          valid_q, valid_d;
    logic [W-1:0]  res_q, res_d;
    logic [RW-1:0] rd_q, rd_d;

    always_comb begin
        valid_d = valid_q & ~ready;
        res_d   = res_q;
        rd_d    = rd_q;
        if (load) begin
            valid_d = 1'b1;
            res_d   = load_res;
            rd_d    = load_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
        end
    end

    assign valid = valid_q;
    assign res   = res_q;
    assign rd    = rd_q;

endmodule

// File: rtl/r200_ex_ctrl.sv
// r200 execute-stage sequencer: ALU/branch issue, iterative divider launch with watchdog,
// and one-cycle redirect/flush for taken control flow.
module r200_ex_ctrl #(
    parameter int DIV_MAX_CYCLES = 40,
    parameter int XLEN           = r200_pkg::XLEN
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           id_valid,
    output logic                           id_ready,
    input  logic                           id_is_branch,
    input  logic                           id_is_jump,
    input  logic                           id_is_div,
    input  logic [r200_pkg::REG_ADDR_W-1:0] id_rd,
    input  logic [XLEN-1:0]                ex_alu_res,
    input  logic                           ex_willbr,
    input  logic [XLEN-1:0]                ex_jumptarg,
    output logic                           div_start,
    input  logic                           div_done,
    input  logic [XLEN-1:0]                div_res,
    output logic                           mem_valid,
    input  logic                           mem_ready,
    output logic [XLEN-1:0]                mem_res,
    output logic [r200_pkg::REG_ADDR_W-1:0] mem_rd,
    output logic                           redirect_valid,
    output logic [XLEN-1:0]                redirect_pc,
    output logic                           flush,
    output logic                           div_err,
    output logic                           dbg_state
);

    import r200_pkg::*;

    localparam int CW = $clog2(DIV_MAX_CYCLES + 1);

    ex_state_t             state_q, state_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  div_start_q, div_start_d;
    logic                  redir_q, redir_d;
    logic [XLEN-1:0]       redir_pc_q, redir_pc_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  load;
    logic [XLEN-1:0]       load_res;
    logic [REG_ADDR_W-1:0] load_rd;

    // Handshake: an instruction moves from ID when id_valid & id_ready in the same cycle.
    assign id_ready = rst_n & (state_q == IDLE) & ~redir_q & (~mem_valid | mem_ready);
    assign accept   = id_valid & id_ready;

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        div_start_d = 1'b0;
        redir_d     = 1'b0;
        redir_pc_d  = '0;
        err_d       = err_q;
        load        = 1'b0;
        load_res    = ex_alu_res;
        load_rd     = id_rd;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (id_is_div) begin
                        state_d     = DIV;
                        div_start_d = 1'b1;
                        rd_d        = id_rd;
                        cnt_d       = '0;
                    end else begin
                        load = 1'b1;
                        if (id_is_jump || (id_is_branch && ex_willbr)) begin
                            redir_d    = 1'b1;
                            redir_pc_d = ex_jumptarg;
                        end
                    end
                end
            end
            DIV: begin
                load_res = div_res;
                load_rd  = rd_q;
                // div_done is not trusted in the launch cycle itself.
                if (div_done && !div_start_q) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CW'(DIV_MAX_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            cnt_q       <= '0;
            div_start_q <= 1'b0;
            redir_q     <= 1'b0;
            redir_pc_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            div_start_q <= div_start_d;
            redir_q     <= redir_d;
            redir_pc_q  <= redir_pc_d;
            err_q       <= err_d;
        end
    end

    r200_pipereg #(
        .W  (XLEN),
        .RW (REG_ADDR_W)
    ) u_pipereg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_res (load_res),
        .load_rd  (load_rd),
        .ready    (mem_ready),
        .valid    (mem_valid),
        .res      (mem_res),
        .rd       (mem_rd)
    );

    assign div_start      = div_start_q;
    assign redirect_valid = redir_q;
    assign redirect_pc    = redir_pc_q;
    assign flush          = redir_q;
    assign div_err        = err_q;
    assign dbg_state      = (state_q == DIV);

endmodule

// File: tb/tb_r200_ex_ctrl.sv
// Self-checking bench for r200_ex_ctrl: scenario tasks plus an EX/MEM result scoreboard.
module tb_r200_ex_ctrl;

    localparam int XLEN = 32;
    localparam int DMAX = 40;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic            id_ready;
    logic            id_is_branch;
    logic            id_is_jump;
    logic            id_is_div;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] ex_alu_res;
    logic            ex_willbr;
    logic [XLEN-1:0] ex_jumptarg;
    logic            div_start;
    logic            div_done;
    logic [XLEN-1:0] div_res;
    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_res;
    logic [4:0]      mem_rd;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            div_err;
    logic            dbg_state;

    r200_ex_ctrl #(
        .DIV_MAX_CYCLES (DMAX),
        .XLEN           (XLEN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_is_branch   (id_is_branch),
        .id_is_jump     (id_is_jump),
        .id_is_div      (id_is_div),
        .id_rd          (id_rd),
        .ex_alu_res     (ex_alu_res),
        .ex_willbr      (ex_willbr),
        .ex_jumptarg    (ex_jumptarg),
        .div_start      (div_start),
        .div_done       (div_done),
        .div_res        (div_res),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_res        (mem_res),
        .mem_rd         (mem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .div_err        (div_err),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    logic [XLEN+4:0] exp_q[$];

    logic            s_id_ready, s_div_start, s_mem_valid, s_redirect_valid, s_flush, s_div_err, s_state;
    logic [XLEN-1:0] s_mem_res, s_redirect_pc;
    logic [4:0]      s_mem_rd;

    // One cycle: sample outputs on the falling edge, run the scoreboard, return just after the rising edge.
    task automatic tick();
        logic [XLEN+4:0] e;
        @(negedge clk);
        s_id_ready       = id_ready;
        s_div_start      = div_start;
        s_mem_valid      = mem_valid;
        s_mem_res        = mem_res;
        s_mem_rd         = mem_rd;
        s_redirect_valid = redirect_valid;
        s_redirect_pc    = redirect_pc;
        s_flush          = flush;
        s_div_err        = div_err;
        s_state          = dbg_state;
        if (rst_n && id_valid && id_ready && !id_is_div)
            exp_q.push_back({id_rd, ex_alu_res});
        if (rst_n && mem_valid && mem_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got rd=%0d res=%h, required no result", mem_rd, mem_res);
            end else begin
                e = exp_q.pop_front();
                if ({mem_rd, mem_res} !== e) begin
                    bad++;
                    $display("FAIL sb_result: got rd=%0d res=%h, required rd=%0d res=%h",
                             mem_rd, mem_res, e[XLEN+4:XLEN], e[XLEN-1:0]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic idle_inputs();
        id_valid     = 1'b0;
        id_is_branch = 1'b0;
        id_is_jump   = 1'b0;
        id_is_div    = 1'b0;
        id_rd        = '0;
        ex_alu_res   = '0;
        ex_willbr    = 1'b0;
        ex_jumptarg  = '0;
        div_done     = 1'b0;
        div_res      = '0;
    endtask

    task automatic drive_op(input logic br, input logic jmp, input logic dv, input logic [4:0] rd,
                            input logic [XLEN-1:0] res, input logic wb, input logic [XLEN-1:0] targ);
        id_valid     = 1'b1;
        id_is_branch = br;
        id_is_jump   = jmp;
        id_is_div    = dv;
        id_rd        = rd;
        ex_alu_res   = res;
        ex_willbr    = wb;
        ex_jumptarg  = targ;
    endtask

    task automatic check_queue_empty(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d pending results, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        idle_inputs();
        tick();
        tick();
        total++;
        if ({s_id_ready, s_div_start, s_mem_valid, s_redirect_valid, s_flush, s_div_err, s_state} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {s_id_ready, s_div_start, s_mem_valid, s_redirect_valid, s_flush, s_div_err, s_state});
        end
        total++;
        if ({s_mem_res, s_mem_rd, s_redirect_pc} !== '0) begin
            bad++;
            $display("FAIL reset_data: got res=%h rd=%0d pc=%h, required 0", s_mem_res, s_mem_rd, s_redirect_pc);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (s_id_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b, required 1", s_id_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] vals[3];
        vals[0] = 32'h11;
        vals[1] = 32'h22;
        vals[2] = 32'h33;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive_op(1'b0, 1'b0, 1'b0, 5'(i + 1), vals[i], 1'b0, '0);
            else idle_inputs();
            tick();
            if (i < 3) begin
                total++;
                if (s_id_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_ready[%0d]: got %b, required 1", i, s_id_ready);
                end
            end
            if (i > 0) begin
                total++;
                if (s_mem_valid !== 1'b1 || s_mem_res !== vals[i-1]) begin
                    bad++;
                    $display("FAIL b2b_result[%0d]: got valid=%b res=%h, required valid=1 res=%h",
                             i, s_mem_valid, s_mem_res, vals[i-1]);
                end
            end
        end
        check_queue_empty("b2b");
    endtask

    task automatic test_branch();
        mem_ready = 1'b1;
        drive_op(1'b1, 1'b0, 1'b0, 5'd2, 32'h44, 1'b1, 32'h100);
        tick();
        drive_op(1'b0, 1'b0, 1'b0, 5'd3, 32'h55, 1'b0, 32'h0);
        tick();
        total++;
        if ({s_redirect_valid, s_flush, s_id_ready} !== 3'b110 || s_redirect_pc !== 32'h100) begin
            bad++;
            $display("FAIL br_taken: got rv=%b fl=%b rdy=%b pc=%h, required rv=1 fl=1 rdy=0 pc=00000100",
                     s_redirect_valid, s_flush, s_id_ready, s_redirect_pc);
        end
        tick();
        total++;
        if (s_id_ready !== 1'b1 || s_redirect_valid !== 1'b0) begin
            bad++;
            $display("FAIL br_after_flush: got rdy=%b rv=%b, required rdy=1 rv=0", s_id_ready, s_redirect_valid);
        end
        drive_op(1'b1, 1'b0, 1'b0, 5'd4, 32'h66, 1'b0, 32'h200);
        tick();
        idle_inputs();
        tick();
        total++;
        if ({s_redirect_valid, s_flush, s_mem_valid} !== 3'b001) begin
            bad++;
            $display("FAIL br_not_taken: got rv=%b fl=%b mv=%b, required rv=0 fl=0 mv=1",
                     s_redirect_valid, s_flush, s_mem_valid);
        end
        drive_op(1'b0, 1'b1, 1'b0, 5'd5, 32'h77, 1'b0, 32'h300);
        tick();
        idle_inputs();
        tick();
        total++;
        if (s_redirect_valid !== 1'b1 || s_redirect_pc !== 32'h300) begin
            bad++;
            $display("FAIL jump: got rv=%b pc=%h, required rv=1 pc=00000300", s_redirect_valid, s_redirect_pc);
        end
        tick();
        check_queue_empty("branch");
    endtask

    task automatic test_div();
        mem_ready = 1'b1;
        // jump flag set alongside div: div must win and no redirect may follow
        drive_op(1'b0, 1'b1, 1'b1, 5'd7, 32'h999, 1'b0, 32'h400);
        tick();
        total++;
        if (s_id_ready !== 1'b1) begin
            bad++;
            $display("FAIL div_accept: got rdy=%b, required 1", s_id_ready);
        end
        drive_op(1'b0, 1'b0, 1'b0, 5'd8, 32'h66, 1'b0, 32'h0);
        div_done = 1'b1;
        div_res  = 32'hBAD;
        tick();
        total++;
        if ({s_div_start, s_state, s_id_ready, s_redirect_valid} !== 4'b1100) begin
            bad++;
            $display("FAIL div_launch: got start=%b st=%b rdy=%b rv=%b, required 1 1 0 0",
                     s_div_start, s_state, s_id_ready, s_redirect_valid);
        end
        div_done = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            total++;
            if ({s_div_start, s_id_ready, s_mem_valid} !== 3'b000) begin
                bad++;
                $display("FAIL div_wait[%0d]: got start=%b rdy=%b mv=%b, required 0 0 0",
                         k, s_div_start, s_id_ready, s_mem_valid);
            end
        end
        div_done = 1'b1;
        div_res  = 32'hDEAD;
        exp_q.push_back({5'd7, 32'hDEAD});
        tick();
        div_done = 1'b0;
        tick();
        total++;
        if (s_mem_valid !== 1'b1 || s_mem_res !== 32'hDEAD || s_mem_rd !== 5'd7 || s_state !== 1'b0
            || s_id_ready !== 1'b1) begin
            bad++;
            $display("FAIL div_result: got mv=%b res=%h rd=%0d st=%b rdy=%b, required 1 0000dead 7 0 1",
                     s_mem_valid, s_mem_res, s_mem_rd, s_state, s_id_ready);
        end
        idle_inputs();
        tick();
        check_queue_empty("div");
    endtask

    task automatic test_backpressure();
        mem_ready = 1'b0;
        drive_op(1'b0, 1'b0, 1'b0, 5'd3, 32'h77, 1'b0, 32'h0);
        tick();
        drive_op(1'b0, 1'b0, 1'b0, 5'd4, 32'h88, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (s_mem_valid !== 1'b1 || s_mem_res !== 32'h77 || s_mem_rd !== 5'd3 || s_id_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got mv=%b res=%h rd=%0d rdy=%b, required 1 00000077 3 0",
                         k, s_mem_valid, s_mem_res, s_mem_rd, s_id_ready);
            end
        end
        mem_ready = 1'b1;
        tick();
        total++;
        if (s_id_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_accept: got rdy=%b, required 1", s_id_ready);
        end
        idle_inputs();
        tick();
        check_queue_empty("bp");
    endtask

    task automatic test_watchdog();
        mem_ready = 1'b1;
        drive_op(1'b0, 1'b0, 1'b1, 5'd9, 32'h0, 1'b0, 32'h0);
        tick();
        idle_inputs();
        tick();
        for (int k = 1; k <= DMAX; k++) begin
            tick();
            if (k == DMAX - 1) begin
                total++;
                if (s_div_err !== 1'b0 || s_state !== 1'b1) begin
                    bad++;
                    $display("FAIL wd_early: got err=%b st=%b, required 0 1", s_div_err, s_state);
                end
            end
            if (k == DMAX) begin
                total++;
                if ({s_div_err, s_state, s_mem_valid, s_id_ready} !== 4'b1001) begin
                    bad++;
                    $display("FAIL wd_expire: got err=%b st=%b mv=%b rdy=%b, required 1 0 0 1",
                             s_div_err, s_state, s_mem_valid, s_id_ready);
                end
            end
        end
        drive_op(1'b0, 1'b0, 1'b0, 5'd1, 32'h12, 1'b0, 32'h0);
        tick();
        idle_inputs();
        tick();
        total++;
        if (s_div_err !== 1'b1) begin
            bad++;
            $display("FAIL wd_sticky: got err=%b, required 1", s_div_err);
        end
        check_queue_empty("wd");
    endtask

    task automatic test_reset_mid_div();
        mem_ready = 1'b1;
        drive_op(1'b0, 1'b0, 1'b1, 5'd10, 32'h0, 1'b0, 32'h0);
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) tick();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({s_id_ready, s_div_start, s_mem_valid, s_redirect_valid, s_flush, s_div_err, s_state} !== 7'b0
            || s_mem_res !== '0 || s_mem_rd !== '0) begin
            bad++;
            $display("FAIL rst_mid_div: got ctrl=%b res=%h rd=%0d, required all 0",
                     {s_id_ready, s_div_start, s_mem_valid, s_redirect_valid, s_flush, s_div_err, s_state},
                     s_mem_res, s_mem_rd);
        end
        rst_n    = 1'b1;
        div_done = 1'b1;
        div_res  = 32'hF00D;
        tick();
        div_done = 1'b0;
        tick();
        tick();
        total++;
        if ({s_mem_valid, s_state, s_div_err, s_div_start, s_id_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL rst_late_done: got mv=%b st=%b err=%b start=%b rdy=%b, required 0 0 0 0 1",
                     s_mem_valid, s_state, s_div_err, s_div_start, s_id_ready);
        end
        check_queue_empty("rst_div");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_back_to_back();
        test_branch();
        test_div();
        test_backpressure();
        test_watchdog();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
